// File: rtl/keccak_hub_pkg.sv
// Shared types and constants for the Keccak accelerator hub: register-bus
// structs, hub register map, pending-bit layout and tracker states.
package keccak_hub_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam logic [7:0] HUB_OFF_PENDING = 8'h00;
  localparam logic [7:0] HUB_OFF_ENABLE  = 8'h04;
  localparam logic [7:0] HUB_OFF_BUSY    = 8'h08;
  localparam logic [7:0] HUB_OFF_TIMEOUT = 8'h0C;

  // Timeout pending bits live in the upper half of IRQ_PENDING.
  localparam int unsigned TO_PEND_BASE = 16;

  localparam logic [0:0] TRK_IDLE_C = 1'b0;
  localparam logic [0:0] TRK_BUSY_C = 1'b1;

  typedef enum logic [0:0] {
    TRK_IDLE = TRK_IDLE_C,
    TRK_BUSY = TRK_BUSY_C
  } trk_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_hub_ch_tracker.sv
// Per-channel permutation tracker: watches starts, done pulses and an
// optional cycle timeout for one Keccak channel.
module keccak_hub_ch_tracker
  import keccak_hub_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        done_i,
  input  logic [31:0] timeout_cfg_i,
  output logic        busy_o,
  output logic        timeout_o
);

  trk_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        expire;

  assign expire = (state_q == TRK_BUSY) && (timeout_cfg_i != 32'd0) &&
                  (cnt_q == timeout_cfg_i - 32'd1);

  // A fresh start always wins; done outranks a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_o = 1'b0;
    if (start_i) begin
      state_d = TRK_BUSY;
      cnt_d   = '0;
    end else if (state_q == TRK_BUSY) begin
      if (done_i) begin
        state_d = TRK_IDLE;
      end else if (expire) begin
        state_d   = TRK_IDLE;
        timeout_o = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TRK_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == TRK_BUSY);

endmodule

// File: rtl/keccak_hub.sv
// Register-bus hub in front of NUM_CH Keccak channels: address-window fan-out,
// per-channel start/done/timeout tracking and an aggregated interrupt.
module keccak_hub
  import keccak_hub_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CH_AW        = 12,
  parameter int unsigned START_OFFSET = 0,
  parameter int unsigned START_BIT    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  reg_req_t              reg_req_i,
  output reg_rsp_t              reg_rsp_o,
  output reg_req_t [NUM_CH-1:0] ch_reg_req_o,
  input  reg_rsp_t [NUM_CH-1:0] ch_reg_rsp_i,
  input  logic [NUM_CH-1:0]     ch_done_i,
  output logic                  irq_o
);

  localparam int unsigned SEL_W     = $clog2(NUM_CH + 1);
  localparam logic [31:0] CH_BITS   = 32'((33'd1 << NUM_CH) - 33'd1);
  localparam logic [31:0] PEND_MASK = CH_BITS | (CH_BITS << TO_PEND_BASE);

  logic [SEL_W-1:0]  sel;
  logic [CH_AW-1:0]  offs;
  logic              hub_sel, hub_hit, hub_we;
  logic [31:0]       wmask, hub_rdata, set_vec;
  logic [31:0]       pend_q, pend_d, en_q, en_d, cfg_q, cfg_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] ch_start, ch_busy, ch_timeout;
  logic              unused_addr;

  assign sel         = reg_req_i.addr[CH_AW +: SEL_W];
  assign offs        = reg_req_i.addr[CH_AW-1:0];
  assign unused_addr = ^reg_req_i.addr;
  assign hub_sel     = (sel == SEL_W'(NUM_CH));
  assign wmask       = strb_mask(reg_req_i.wstrb);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_reg_req_o[gi] = '{
      addr:  reg_req_i.addr,
      write: reg_req_i.write,
      wdata: reg_req_i.wdata,
      wstrb: reg_req_i.wstrb,
      valid: reg_req_i.valid && (sel == SEL_W'(gi))
    };

    // Only a write the channel actually accepted counts as a launch.
    assign ch_start[gi] = ch_reg_req_o[gi].valid && reg_req_i.write &&
                          ch_reg_rsp_i[gi].ready && !ch_reg_rsp_i[gi].error &&
                          (offs == CH_AW'(START_OFFSET)) &&
                          reg_req_i.wdata[START_BIT] && reg_req_i.wstrb[START_BIT/8];

    keccak_hub_ch_tracker u_tracker (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (ch_start[gi]),
      .done_i        (ch_done_i[gi]),
      .timeout_cfg_i (cfg_q),
      .busy_o        (ch_busy[gi]),
      .timeout_o     (ch_timeout[gi])
    );
  end

  always_comb begin
    set_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      set_vec[c]                = ch_done_i[c];
      set_vec[TO_PEND_BASE + c] = ch_timeout[c];
    end
  end

  always_comb begin
    hub_hit   = 1'b1;
    hub_rdata = '0;
    case (offs)
      CH_AW'(HUB_OFF_PENDING): hub_rdata = pend_q;
      CH_AW'(HUB_OFF_ENABLE):  hub_rdata = en_q;
      CH_AW'(HUB_OFF_BUSY):    hub_rdata = 32'(ch_busy);
      CH_AW'(HUB_OFF_TIMEOUT): hub_rdata = cfg_q;
      default:                 hub_hit   = 1'b0;
    endcase
  end

  always_comb begin
    reg_rsp_o = '{rdata: 32'd0, error: 1'b1, ready: 1'b1};
    if (hub_sel) begin
      reg_rsp_o.rdata = hub_hit ? hub_rdata : 32'd0;
      reg_rsp_o.error = !hub_hit;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == SEL_W'(c)) begin
        reg_rsp_o = ch_reg_rsp_i[c];
      end
    end
  end

  assign hub_we = reg_req_i.valid && reg_req_i.write && hub_sel && hub_hit;

  // Hardware sets are OR-ed in after the W1C so a coincident set survives.
  always_comb begin
    pend_d = pend_q;
    en_d   = en_q;
    cfg_d  = cfg_q;
    if (hub_we) begin
      case (offs)
        CH_AW'(HUB_OFF_PENDING): pend_d = pend_q & ~(reg_req_i.wdata & wmask);
        CH_AW'(HUB_OFF_ENABLE):  en_d   = (en_q & ~wmask) | (reg_req_i.wdata & wmask);
        CH_AW'(HUB_OFF_TIMEOUT): cfg_d  = (cfg_q & ~wmask) | (reg_req_i.wdata & wmask);
        default: ;
      endcase
    end
    pend_d = (pend_d | set_vec) & PEND_MASK;
  end

  assign irq_d = |(pend_q & en_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      en_q   <= '0;
      cfg_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      cfg_q  <= cfg_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_keccak_hub.sv
// Scoreboard bench for keccak_hub: directed scenarios then random bus traffic,
// checked against a cycle-stepped behavioural model of the hub.
module tb_keccak_hub;
  import keccak_hub_pkg::*;

  localparam int NUM_CH = 2;

  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] rdata;
    int          id;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  reg_req_t              req;
  reg_rsp_t              rsp;
  reg_req_t [NUM_CH-1:0] ch_req;
  reg_rsp_t [NUM_CH-1:0] ch_rsp;
  logic [NUM_CH-1:0]     done;
  logic                  irq;

  int   checks   = 0;
  int   failures = 0;
  int   txn_id   = 0;
  exp_t exp_q[$];
  bit          fix_on;
  logic [31:0] fix_rdata;
  bit          fix_err;

  // Behavioural model state: busy flag and launch edge per channel.
  bit          m_busy[NUM_CH];
  longint      m_start[NUM_CH];
  logic [31:0] m_pend = '0, m_en = '0, m_cfg = '0;
  bit          m_irq = 1'b0;
  longint      edge_n = 0;

  keccak_hub #(
    .NUM_CH(NUM_CH), .CH_AW(12), .START_OFFSET(0), .START_BIT(0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_req_i    (req),
    .reg_rsp_o    (rsp),
    .ch_reg_req_o (ch_req),
    .ch_reg_rsp_i (ch_rsp),
    .ch_done_i    (done),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] chan_word(input int c, input logic [31:0] a);
    return 32'hA500_0000 | (32'(c) << 16) | {16'd0, a[15:0]};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      ch_rsp[c] = '{rdata: chan_word(c, ch_req[c].addr), error: 1'b0, ready: 1'b1};
  end

  function automatic void model_rsp(input logic [31:0] a, output logic [31:0] rd, output bit er);
    int sel;
    int off;
    logic [31:0] busy_v;
    sel = int'(a[13:12]);
    off = int'(a[11:0]);
    busy_v = '0;
    for (int c = 0; c < NUM_CH; c++) busy_v[c] = m_busy[c];
    rd = '0;
    er = 1'b0;
    if (sel < NUM_CH) rd = chan_word(sel, a);
    else if (sel == NUM_CH) begin
      case (off)
        0:  rd = m_pend;
        4:  rd = m_en;
        8:  rd = busy_v;
        12: rd = m_cfg;
        default: er = 1'b1;
      endcase
    end else er = 1'b1;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] pend_n;
    logic [31:0] m;
    bit st;
    bit hubw;
    int sel;
    int off;
    edge_n++;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) m_busy[c] = 1'b0;
      m_pend = '0;
      m_en   = '0;
      m_cfg  = '0;
      m_irq  = 1'b0;
    end else begin
      sel  = int'(req.addr[13:12]);
      off  = int'(req.addr[11:0]);
      m    = byte_mask(req.wstrb);
      hubw = req.valid && req.write && (sel == NUM_CH);
      pend_n = m_pend;
      if (hubw && off == 0) pend_n = pend_n & ~(req.wdata & m);
      for (int c = 0; c < NUM_CH; c++) begin
        st = req.valid && req.write && (sel == c) && (off == 0) && req.wdata[0] && req.wstrb[0];
        if (st) begin
          m_busy[c]  = 1'b1;
          m_start[c] = edge_n;
        end else if (m_busy[c] && done[c]) begin
          m_busy[c] = 1'b0;
        end else if (m_busy[c] && m_cfg != 0 && (edge_n - m_start[c]) == longint'(m_cfg)) begin
          m_busy[c] = 1'b0;
          pend_n[16 + c] = 1'b1;
        end
        if (done[c]) pend_n[c] = 1'b1;
      end
      m_irq  = |(m_pend & m_en);
      m_pend = pend_n;
      if (hubw && off == 4)  m_en  = (m_en & ~m) | (req.wdata & m);
      if (hubw && off == 12) m_cfg = (m_cfg & ~m) | (req.wdata & m);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    reg_req_t fwd;
    checks++;
    if (irq !== m_irq) begin
      failures++;
      $display("FAIL irq_o actual=%b required=%b t=%0t", irq, m_irq, $time);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      fwd = req;
      fwd.valid = req.valid && (int'(req.addr[13:12]) == c);
      checks++;
      if (ch_req[c] !== fwd) begin
        failures++;
        $display("FAIL fwd_ch%0d actual=%h required=%h", c, ch_req[c], fwd);
      end
    end
    if (req.valid) begin
      checks++;
      if (rsp.ready !== 1'b1) begin
        failures++;
        $display("FAIL rsp_ready actual=%b required=1 addr=%h", rsp.ready, req.addr);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty actual=0 entries required>=1 addr=%h", req.addr);
      end else begin
        e = exp_q.pop_front();
        if (rsp.error !== e.err) begin
          failures++;
          $display("FAIL txn%0d_error actual=%b required=%b addr=%h", e.id, rsp.error, e.err, req.addr);
        end
        if (!e.w) begin
          checks++;
          if (rsp.rdata !== e.rdata) begin
            failures++;
            $display("FAIL txn%0d_rdata actual=%h required=%h addr=%h", e.id, rsp.rdata, e.rdata, req.addr);
          end
        end
        $display("txn %0d %s addr=%h wdata=%h rdata=%h err=%b", e.id, e.w ? "WR" : "RD",
                 req.addr, req.wdata, rsp.rdata, rsp.error);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic cyc();
    exp_t e;
    if (req.valid) begin
      model_rsp(req.addr, e.rdata, e.err);
      if (fix_on) begin
        e.rdata = fix_rdata;
        e.err   = fix_err;
      end
      e.w  = req.write;
      e.id = txn_id++;
      exp_q.push_back(e);
    end
    fix_on = 1'b0;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    done      = '0;
    rst       = 1'b0;
  endtask

  task automatic drv(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req = '{addr: a, write: w, wdata: d, wstrb: s, valid: 1'b1};
  endtask

  task automatic rd_fix(input logic [31:0] a, input logic [31:0] v, input bit er);
    drv(1'b0, a, 32'd0, 4'h0);
    fix_on    = 1'b1;
    fix_rdata = v;
    fix_err   = er;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin : stim
    int kind;
    int c;
    logic [31:0] wd;
    rst    = 1'b1;
    req    = '0;
    done   = '0;
    fix_on = 1'b0;
    repeat (3) begin
      rst = 1'b1;
      cyc();
    end
    // Reset state of every hub register.
    rd_fix(32'h2000, 32'h0, 1'b0); cyc();
    rd_fix(32'h2004, 32'h0, 1'b0); cyc();
    rd_fix(32'h2008, 32'h0, 1'b0); cyc();
    rd_fix(32'h200C, 32'h0, 1'b0); cyc();

    // Channel 1 launch, done ten cycles later, enabled interrupt.
    drv(1'b1, 32'h2004, 32'h2, 4'hF); cyc();
    drv(1'b1, 32'h1000, 32'h1, 4'hF); cyc();
    for (int k = 0; k < 9; k++) begin
      if (k == 4) rd_fix(32'h2008, 32'h2, 1'b0);
      cyc();
    end
    done = 2'b10; cyc();
    check("irq_same_cycle_as_pending", 32'(irq), 32'h0);
    cyc();
    check("irq_after_done", 32'(irq), 32'h1);
    rd_fix(32'h2000, 32'h2, 1'b0); cyc();
    drv(1'b1, 32'h2000, 32'h2, 4'hF); cyc();

    // Timeout of channel 0 after five cycles, then W1C.
    drv(1'b1, 32'h200C, 32'd5, 4'hF); cyc();
    drv(1'b1, 32'h2004, 32'h10000, 4'hF); cyc();
    idle(2);
    drv(1'b1, 32'h0000, 32'h1, 4'hF); cyc();
    idle(4);
    rd_fix(32'h2008, 32'h1, 1'b0); cyc();
    rd_fix(32'h2008, 32'h0, 1'b0); cyc();
    rd_fix(32'h2000, 32'h10000, 1'b0); cyc();
    check("irq_after_timeout", 32'(irq), 32'h1);
    drv(1'b1, 32'h2000, 32'h10000, 4'hF); cyc();
    check("irq_held_one_cycle", 32'(irq), 32'h1);
    cyc();
    check("irq_dropped", 32'(irq), 32'h0);

    // Set beats a coincident W1C.
    done = 2'b01;
    drv(1'b1, 32'h2000, 32'h1, 4'hF); cyc();
    rd_fix(32'h2000, 32'h1, 1'b0); cyc();
    drv(1'b1, 32'h2000, 32'h1, 4'hF); cyc();

    // Unmapped window and unmapped hub offset.
    rd_fix(32'h3000, 32'h0, 1'b1); cyc();
    rd_fix(32'h2010, 32'h0, 1'b1); cyc();
    drv(1'b1, 32'h3004, 32'hFFFF_FFFF, 4'hF); cyc();
    drv(1'b1, 32'h2010, 32'hFFFF_FFFF, 4'hF); cyc();
    rd_fix(32'h2004, 32'h10000, 1'b0); cyc();

    // Reset while channel 0 counts at 3.
    drv(1'b1, 32'h0000, 32'h1, 4'hF); cyc();
    idle(3);
    rst = 1'b1; cyc();
    idle(10);
    rd_fix(32'h2000, 32'h0, 1'b0); cyc();
    rd_fix(32'h2004, 32'h0, 1'b0); cyc();
    rd_fix(32'h2008, 32'h0, 1'b0); cyc();
    rd_fix(32'h200C, 32'h0, 1'b0); cyc();

    // Random traffic.
    drv(1'b1, 32'h200C, 32'd7, 4'hF); cyc();
    drv(1'b1, 32'h2004, 32'h0003_0003, 4'hF); cyc();
    for (int i = 0; i < 1500; i++) begin
      kind = int'($urandom_range(0, 9));
      c    = int'($urandom_range(0, NUM_CH - 1));
      wd   = $urandom;
      case (kind)
        0, 1, 2: begin
          if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
          drv(1'b1, 32'(c) << 12, wd, ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom));
        end
        3: drv(1'($urandom), (32'(c) << 12) | (32'($urandom_range(0, 1023)) << 2), wd, 4'($urandom));
        4, 5: drv(1'b0, 32'h2000 | (32'($urandom_range(0, 4)) << 2), 32'd0, 4'h0);
        6: drv(1'b1, 32'h2000, wd, 4'hF);
        7: begin
          if ($urandom_range(0, 1) == 0) drv(1'b1, 32'h2004, wd, 4'($urandom));
          else drv(1'b1, 32'h200C, 32'($urandom_range(0, 12)), ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom));
        end
        8: drv(1'($urandom), 32'h3000 | (32'($urandom_range(0, 1023)) << 2), wd, 4'hF);
        default: req.valid = 1'b0;
      endcase
      for (int k = 0; k < NUM_CH; k++)
        done[k] = ($urandom_range(0, 11) == 0) && !(kind <= 2 && k == c);
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc();
    end
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
